// File: rtl/bellek_islem_birimi_pkg.sv
// rtl/bellek_islem_birimi_pkg.sv - shared widths, micro-op codes, FSM states and op helpers
package bellek_islem_birimi_pkg;

   // Default widths for the load/store path
   localparam int VARS_ADRES_BIT = 32;
   localparam int VARS_VERI_BIT  = 32;
   localparam int VARS_RD_BIT    = 5;

   // Load/store micro-op codes as presented by the pipeline
   typedef enum logic [2:0] {
      BIB_LB  = 3'd0,
      BIB_LH  = 3'd1,
      BIB_LW  = 3'd2,
      BIB_LBU = 3'd3,
      BIB_LHU = 3'd4,
      BIB_SB  = 3'd5,
      BIB_SH  = 3'd6,
      BIB_SW  = 3'd7
   } bib_islem_e;

   // Access size classes
   localparam logic [1:0] BOYUT_BYTE  = 2'd0;
   localparam logic [1:0] BOYUT_YARIM = 2'd1;
   localparam logic [1:0] BOYUT_KELIME = 2'd2;

   // Controller states
   localparam logic [1:0] DURUM_BOSTA = 2'd0;
   localparam logic [1:0] DURUM_ISTEK = 2'd1;
   localparam logic [1:0] DURUM_BEKLE = 2'd2;
   localparam logic [1:0] DURUM_SONUC = 2'd3;

   // Size class of an op; anything unrecognised behaves as a word access
   function automatic logic [1:0] boyut_kodu(input logic [2:0] islem);
      case (islem)
         BIB_LB, BIB_LBU, BIB_SB: boyut_kodu = BOYUT_BYTE;
         BIB_LH, BIB_LHU, BIB_SH: boyut_kodu = BOYUT_YARIM;
         default:                 boyut_kodu = BOYUT_KELIME;
      endcase
   endfunction

   // True for store ops
   function automatic logic yazma_mi(input logic [2:0] islem);
      yazma_mi = (islem == BIB_SB) || (islem == BIB_SH) || (islem == BIB_SW);
   endfunction

endpackage

// File: rtl/bib_hizalayici.sv
// rtl/bib_hizalayici.sv - byte-lane aligner: mask, store shift, load extend, misalignment check
module bib_hizalayici
   import bellek_islem_birimi_pkg::*;
#(
   parameter int VERI_BIT  = 32,
   parameter int VERI_BYTE = VERI_BIT / 8
) (
   input  logic [2:0]           islem,
   input  logic [1:0]           ofset,
   input  logic [VERI_BIT-1:0]  yaz_veri_ham,
   input  logic [VERI_BIT-1:0]  oku_kelime,
   output logic [VERI_BYTE-1:0] maske,
   output logic [VERI_BIT-1:0]  yaz_veri,
   output logic [VERI_BIT-1:0]  oku_veri,
   output logic                 hizasiz
);

   logic [4:0]          kaydirma;
   logic [VERI_BIT-1:0] kayik;

   // Lane placement of store data and size-based mask / alignment check
   always_comb begin
      kaydirma = {ofset, 3'b000};
      yaz_veri = yaz_veri_ham << kaydirma;
      case (boyut_kodu(islem))
         BOYUT_BYTE: begin
            maske   = VERI_BYTE'(1) << ofset;
            hizasiz = 1'b0;
         end
         BOYUT_YARIM: begin
            maske   = VERI_BYTE'(3) << ofset;
            hizasiz = ofset[0];
         end
         default: begin
            maske   = '1;
            hizasiz = |ofset;
         end
      endcase
   end

   // Pull the addressed lane down to bit 0 and extend by op type
   always_comb begin
      kayik = oku_kelime >> kaydirma;
      case (islem)
         BIB_LB:  oku_veri = {{(VERI_BIT-8){kayik[7]}}, kayik[7:0]};
         BIB_LH:  oku_veri = {{(VERI_BIT-16){kayik[15]}}, kayik[15:0]};
         BIB_LBU: oku_veri = {{(VERI_BIT-8){1'b0}}, kayik[7:0]};
         BIB_LHU: oku_veri = {{(VERI_BIT-16){1'b0}}, kayik[15:0]};
         default: oku_veri = kayik;
      endcase
   end

endmodule

// File: rtl/bellek_islem_birimi.sv
// rtl/bellek_islem_birimi.sv - memory-stage load/store unit in front of the data-bus unit
module bellek_islem_birimi
   import bellek_islem_birimi_pkg::*;
#(
   parameter int ADRES_BIT = VARS_ADRES_BIT,
   parameter int VERI_BIT  = VARS_VERI_BIT,
   parameter int RD_BIT    = VARS_RD_BIT,
   parameter int VERI_BYTE = VERI_BIT / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 bib_gecerli_i,
   input  logic [2:0]           bib_islem_i,
   input  logic [ADRES_BIT-1:0] bib_adres_i,
   input  logic [VERI_BIT-1:0]  bib_veri_i,
   input  logic [RD_BIT-1:0]    bib_rd_i,
   output logic                 bib_durdur_o,
   output logic                 sonuc_gecerli_o,
   output logic [VERI_BIT-1:0]  sonuc_veri_o,
   output logic [RD_BIT-1:0]    sonuc_rd_o,
   output logic                 hizasiz_o,
   output logic                 vyb_istek_gecerli_o,
   output logic                 vyb_istek_yaz_o,
   output logic                 vyb_istek_oku_o,
   output logic [ADRES_BIT-1:0] vyb_adres_o,
   output logic [VERI_BIT-1:0]  vyb_veri_o,
   output logic [VERI_BYTE-1:0] vyb_maske_o,
   input  logic                 vyb_hazir_i,
   input  logic [VERI_BIT-1:0]  vyb_veri_i,
   input  logic                 vyb_gecerli_i
);

   logic [1:0]           durum;
   logic [2:0]           islem_q;
   logic [ADRES_BIT-1:0] adres_q;
   logic [VERI_BIT-1:0]  veri_q;
   logic [RD_BIT-1:0]    rd_q;
   logic [VERI_BIT-1:0]  sonuc_veri_q;
   logic                 hizasiz_q;

   logic                 bostada;
   logic                 istekte;
   logic [2:0]           h_islem;
   logic [1:0]           h_ofset;
   logic [VERI_BYTE-1:0] h_maske;
   logic [VERI_BIT-1:0]  h_yaz_veri;
   logic [VERI_BIT-1:0]  h_oku_veri;
   logic                 h_hizasiz;

   assign bostada = (durum == DURUM_BOSTA);
   assign istekte = (durum == DURUM_ISTEK);

   // The aligner looks at the incoming op while idle (alignment check) and at the latched op afterwards
   assign h_islem = bostada ? bib_islem_i      : islem_q;
   assign h_ofset = bostada ? bib_adres_i[1:0] : adres_q[1:0];

   bib_hizalayici #(
      .VERI_BIT  (VERI_BIT),
      .VERI_BYTE (VERI_BYTE)
   ) u_hizalayici (
      .islem        (h_islem),
      .ofset        (h_ofset),
      .yaz_veri_ham (veri_q),
      .oku_kelime   (vyb_veri_i),
      .maske        (h_maske),
      .yaz_veri     (h_yaz_veri),
      .oku_veri     (h_oku_veri),
      .hizasiz      (h_hizasiz)
   );

   // Request/completion sequencing and result capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum        <= DURUM_BOSTA;
         islem_q      <= '0;
         adres_q      <= '0;
         veri_q       <= '0;
         rd_q         <= '0;
         sonuc_veri_q <= '0;
         hizasiz_q    <= 1'b0;
      end else begin
         case (durum)
            DURUM_BOSTA: begin
               if (bib_gecerli_i) begin
                  islem_q      <= bib_islem_i;
                  adres_q      <= bib_adres_i;
                  veri_q       <= bib_veri_i;
                  rd_q         <= bib_rd_i;
                  sonuc_veri_q <= '0;
                  hizasiz_q    <= h_hizasiz;
                  durum        <= h_hizasiz ? DURUM_SONUC : DURUM_ISTEK;
               end
            end
            DURUM_ISTEK: begin
               if (vyb_hazir_i) begin
                  durum <= DURUM_BEKLE;
               end
            end
            DURUM_BEKLE: begin
               if (vyb_gecerli_i) begin
                  if (!yazma_mi(islem_q)) begin
                     sonuc_veri_q <= h_oku_veri;
                  end
                  durum <= DURUM_SONUC;
               end
            end
            default: begin
               durum <= DURUM_BOSTA;
            end
         endcase
      end
   end

   // Request fields are only driven while the request is outstanding
   assign vyb_istek_gecerli_o = istekte;
   assign vyb_istek_yaz_o     = istekte &&  yazma_mi(islem_q);
   assign vyb_istek_oku_o     = istekte && !yazma_mi(islem_q);
   assign vyb_adres_o         = istekte ? {adres_q[ADRES_BIT-1:2], 2'b00} : '0;
   assign vyb_veri_o          = istekte ? h_yaz_veri : '0;
   assign vyb_maske_o         = istekte ? h_maske    : '0;

   assign sonuc_gecerli_o = (durum == DURUM_SONUC);
   assign sonuc_veri_o    = sonuc_veri_q;
   assign sonuc_rd_o      = rd_q;
   assign hizasiz_o       = hizasiz_q;
   assign bib_durdur_o    = bib_gecerli_i && (durum != DURUM_SONUC);

endmodule

// File: tb/tb_bellek_islem_birimi.sv
// tb/tb_bellek_islem_birimi.sv - directed self-checking bench for bellek_islem_birimi
module tb_bellek_islem_birimi;
   import bellek_islem_birimi_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        bib_gecerli_i;
   logic [2:0]  bib_islem_i;
   logic [31:0] bib_adres_i;
   logic [31:0] bib_veri_i;
   logic [4:0]  bib_rd_i;
   logic        bib_durdur_o;
   logic        sonuc_gecerli_o;
   logic [31:0] sonuc_veri_o;
   logic [4:0]  sonuc_rd_o;
   logic        hizasiz_o;
   logic        vyb_istek_gecerli_o;
   logic        vyb_istek_yaz_o;
   logic        vyb_istek_oku_o;
   logic [31:0] vyb_adres_o;
   logic [31:0] vyb_veri_o;
   logic [3:0]  vyb_maske_o;
   logic        vyb_hazir_i;
   logic [31:0] vyb_veri_i;
   logic        vyb_gecerli_i;

   int vektor_sayisi = 0;
   int hata_sayisi   = 0;

   bellek_islem_birimi dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .bib_gecerli_i       (bib_gecerli_i),
      .bib_islem_i         (bib_islem_i),
      .bib_adres_i         (bib_adres_i),
      .bib_veri_i          (bib_veri_i),
      .bib_rd_i            (bib_rd_i),
      .bib_durdur_o        (bib_durdur_o),
      .sonuc_gecerli_o     (sonuc_gecerli_o),
      .sonuc_veri_o        (sonuc_veri_o),
      .sonuc_rd_o          (sonuc_rd_o),
      .hizasiz_o           (hizasiz_o),
      .vyb_istek_gecerli_o (vyb_istek_gecerli_o),
      .vyb_istek_yaz_o     (vyb_istek_yaz_o),
      .vyb_istek_oku_o     (vyb_istek_oku_o),
      .vyb_adres_o         (vyb_adres_o),
      .vyb_veri_o          (vyb_veri_o),
      .vyb_maske_o         (vyb_maske_o),
      .vyb_hazir_i         (vyb_hazir_i),
      .vyb_veri_i          (vyb_veri_i),
      .vyb_gecerli_i       (vyb_gecerli_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
      vektor_sayisi++;
      if (gozlenen !== beklenen) begin
         hata_sayisi++;
         $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic hepsi_sifir(input string ad);
      kontrol({ad, "_istek"},  32'(vyb_istek_gecerli_o), 32'd0);
      kontrol({ad, "_yaz"},    32'(vyb_istek_yaz_o), 32'd0);
      kontrol({ad, "_oku"},    32'(vyb_istek_oku_o), 32'd0);
      kontrol({ad, "_adres"},  vyb_adres_o, 32'd0);
      kontrol({ad, "_vveri"},  vyb_veri_o, 32'd0);
      kontrol({ad, "_maske"},  32'(vyb_maske_o), 32'd0);
      kontrol({ad, "_sgec"},   32'(sonuc_gecerli_o), 32'd0);
      kontrol({ad, "_sveri"},  sonuc_veri_o, 32'd0);
      kontrol({ad, "_rd"},     32'(sonuc_rd_o), 32'd0);
      kontrol({ad, "_hiz"},    32'(hizasiz_o), 32'd0);
      kontrol({ad, "_durdur"}, 32'(bib_durdur_o), 32'd0);
   endtask

   task automatic istek_kontrol(input string ad, input logic yaz, input logic [31:0] e_adres,
                                input logic [3:0] e_maske, input logic [31:0] e_vveri);
      kontrol({ad, "_istek"},  32'(vyb_istek_gecerli_o), 32'd1);
      kontrol({ad, "_yaz"},    32'(vyb_istek_yaz_o), 32'(yaz));
      kontrol({ad, "_oku"},    32'(vyb_istek_oku_o), 32'(!yaz));
      kontrol({ad, "_adres"},  vyb_adres_o, e_adres);
      kontrol({ad, "_maske"},  32'(vyb_maske_o), 32'(e_maske));
      kontrol({ad, "_vveri"},  vyb_veri_o, e_vveri);
      kontrol({ad, "_durdur"}, 32'(bib_durdur_o), 32'd1);
      kontrol({ad, "_sgec"},   32'(sonuc_gecerli_o), 32'd0);
   endtask

   // Runs one aligned access; called and returns on a negedge
   task automatic calistir(input string ad, input logic [2:0] op, input logic [31:0] adr,
                           input logic [31:0] veri, input logic [4:0] rd,
                           input int hazir_bekle, input int gec_bekle, input logic [31:0] kelime,
                           input logic yaz, input logic [31:0] e_adres, input logic [3:0] e_maske,
                           input logic [31:0] e_vveri, input logic [31:0] e_sonuc);
      bib_gecerli_i = 1'b1;
      bib_islem_i   = op;
      bib_adres_i   = adr;
      bib_veri_i    = veri;
      bib_rd_i      = rd;
      vyb_hazir_i   = (hazir_bekle == 0);
      #1;
      kontrol({ad, "_durdur0"}, 32'(bib_durdur_o), 32'd1);
      kontrol({ad, "_istek0"},  32'(vyb_istek_gecerli_o), 32'd0);
      @(negedge clk_i);
      for (int i = 0; i < hazir_bekle; i++) begin
         istek_kontrol({ad, "_bekl"}, yaz, e_adres, e_maske, e_vveri);
         vyb_gecerli_i = 1'b1;
         vyb_veri_i    = 32'hBAD0BAD0;
         @(negedge clk_i);
      end
      vyb_gecerli_i = 1'b0;
      vyb_hazir_i   = 1'b1;
      istek_kontrol(ad, yaz, e_adres, e_maske, e_vveri);
      @(negedge clk_i);
      for (int j = 0; j < gec_bekle; j++) begin
         kontrol({ad, "_bekle_istek"},  32'(vyb_istek_gecerli_o), 32'd0);
         kontrol({ad, "_bekle_durdur"}, 32'(bib_durdur_o), 32'd1);
         kontrol({ad, "_bekle_sgec"},   32'(sonuc_gecerli_o), 32'd0);
         @(negedge clk_i);
      end
      kontrol({ad, "_bekle_istek"}, 32'(vyb_istek_gecerli_o), 32'd0);
      vyb_gecerli_i = 1'b1;
      vyb_veri_i    = kelime;
      @(negedge clk_i);
      vyb_gecerli_i = 1'b0;
      vyb_veri_i    = 32'h0;
      kontrol({ad, "_sgec"},   32'(sonuc_gecerli_o), 32'd1);
      kontrol({ad, "_sveri"},  sonuc_veri_o, e_sonuc);
      kontrol({ad, "_rd"},     32'(sonuc_rd_o), 32'(rd));
      kontrol({ad, "_hiz"},    32'(hizasiz_o), 32'd0);
      kontrol({ad, "_durdur"}, 32'(bib_durdur_o), 32'd0);
      bib_gecerli_i = 1'b0;
      @(negedge clk_i);
      kontrol({ad, "_sgec_son"}, 32'(sonuc_gecerli_o), 32'd0);
   endtask

   // Misaligned op: no request, fault reported the next cycle
   task automatic hizasiz_calistir(input string ad, input logic [2:0] op, input logic [31:0] adr,
                                   input logic [4:0] rd);
      bib_gecerli_i = 1'b1;
      bib_islem_i   = op;
      bib_adres_i   = adr;
      bib_veri_i    = 32'h55555555;
      bib_rd_i      = rd;
      #1;
      kontrol({ad, "_durdur0"}, 32'(bib_durdur_o), 32'd1);
      @(negedge clk_i);
      kontrol({ad, "_istek"},  32'(vyb_istek_gecerli_o), 32'd0);
      kontrol({ad, "_sgec"},   32'(sonuc_gecerli_o), 32'd1);
      kontrol({ad, "_hiz"},    32'(hizasiz_o), 32'd1);
      kontrol({ad, "_sveri"},  sonuc_veri_o, 32'd0);
      kontrol({ad, "_rd"},     32'(sonuc_rd_o), 32'(rd));
      kontrol({ad, "_durdur"}, 32'(bib_durdur_o), 32'd0);
      bib_gecerli_i = 1'b0;
      @(negedge clk_i);
      kontrol({ad, "_sgec_son"}, 32'(sonuc_gecerli_o), 32'd0);
      kontrol({ad, "_istek_son"}, 32'(vyb_istek_gecerli_o), 32'd0);
   endtask

   initial begin
      rst_i         = 1'b1;
      bib_gecerli_i = 1'b0;
      bib_islem_i   = 3'd0;
      bib_adres_i   = 32'h0;
      bib_veri_i    = 32'h0;
      bib_rd_i      = 5'd0;
      vyb_hazir_i   = 1'b0;
      vyb_veri_i    = 32'h0;
      vyb_gecerli_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      hepsi_sifir("reset");
      rst_i = 1'b0;
      @(negedge clk_i);

      //        ad      op       adr           veri          rd    hb gb kelime        yaz  e_adres       maske  e_vveri       e_sonuc
      calistir("sw",   BIB_SW,  32'h00000100, 32'hDEADBEEF, 5'd3, 0, 0, 32'h0,        1'b1, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'h0);
      calistir("sb",   BIB_SB,  32'h00000103, 32'h000000AB, 5'd4, 0, 0, 32'h0,        1'b1, 32'h00000100, 4'h8, 32'hAB000000, 32'h0);
      calistir("sh",   BIB_SH,  32'h00000102, 32'h00001234, 5'd5, 0, 1, 32'h0,        1'b1, 32'h00000100, 4'hC, 32'h12340000, 32'h0);
      calistir("lb",   BIB_LB,  32'h00000102, 32'h0,        5'd6, 0, 0, 32'h0080FF00, 1'b0, 32'h00000100, 4'h4, 32'h0,        32'hFFFFFF80);
      calistir("lbu",  BIB_LBU, 32'h00000102, 32'h0,        5'd7, 0, 0, 32'h0080FF00, 1'b0, 32'h00000100, 4'h4, 32'h0,        32'h00000080);
      calistir("lb1",  BIB_LB,  32'h00000101, 32'h0,        5'd8, 1, 0, 32'h0000FF00, 1'b0, 32'h00000100, 4'h2, 32'h0,        32'hFFFFFFFF);
      calistir("lh",   BIB_LH,  32'h00000102, 32'h0,        5'd9, 0, 2, 32'h80010000, 1'b0, 32'h00000100, 4'hC, 32'h0,        32'hFFFF8001);
      calistir("lhu",  BIB_LHU, 32'h00000102, 32'h0,        5'd10,0, 0, 32'h80010000, 1'b0, 32'h00000100, 4'hC, 32'h0,        32'h00008001);
      calistir("lh0",  BIB_LH,  32'h00000100, 32'h0,        5'd11,0, 0, 32'hFFFF7FFE, 1'b0, 32'h00000100, 4'h3, 32'h0,        32'h00007FFE);
      calistir("lw",   BIB_LW,  32'h00000200, 32'h0,        5'd12,5, 3, 32'h12345678, 1'b0, 32'h00000200, 4'hF, 32'h0,        32'h12345678);

      hizasiz_calistir("lh_hiz", BIB_LH, 32'h00000101, 5'd13);
      hizasiz_calistir("lw_hiz", BIB_LW, 32'h00000102, 5'd14);
      hizasiz_calistir("sh_hiz", BIB_SH, 32'h00000103, 5'd15);

      // Reset while waiting for completion
      bib_gecerli_i = 1'b1;
      bib_islem_i   = BIB_LW;
      bib_adres_i   = 32'h00000300;
      bib_rd_i      = 5'd7;
      vyb_hazir_i   = 1'b1;
      @(negedge clk_i);
      kontrol("rst_istek", 32'(vyb_istek_gecerli_o), 32'd1);
      @(negedge clk_i);
      kontrol("rst_bekle", 32'(vyb_istek_gecerli_o), 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i         = 1'b0;
      bib_gecerli_i = 1'b0;
      #1;
      hepsi_sifir("rst_mid");
      vyb_gecerli_i = 1'b1;
      vyb_veri_i    = 32'hCAFEF00D;
      @(negedge clk_i);
      vyb_gecerli_i = 1'b0;
      kontrol("rst_gec_sgec", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rst_gec_istek", 32'(vyb_istek_gecerli_o), 32'd0);
      @(negedge clk_i);
      kontrol("rst_gec_sgec2", 32'(sonuc_gecerli_o), 32'd0);
      kontrol("rst_gec_sveri", sonuc_veri_o, 32'd0);

      // Unit still works after the mid-transaction reset
      calistir("sonra", BIB_LW, 32'h00000404, 32'h0, 5'd2, 0, 0, 32'hA5A55A5A, 1'b0, 32'h00000404, 4'hF, 32'h0, 32'hA5A55A5A);

      $display("== %0d vectors applied, %0d miscompares ==", vektor_sayisi, hata_sayisi);
      $finish;
   end

endmodule
